// File: rtl/ptmch_spi_cmd_match.sv
// ptmch_spi_cmd_match
// Passive SPI NAND command snooper. Decodes the host-to-flash MOSI stream
// (SPI mode 0, MSB first) and recognises five commands. Each command's
// address/data field is compared against an inclusive window. Every hit
// increments that command's 32-bit counter and produces a trigger pulse.
//
// Ports:
//   CLK100M, RESET_N          system clock, asynchronous active-low reset
//   SPI_CS_N/SCK/MOSI         snooped SPI bus (asynchronous to CLK100M)
//   CNT_CLR                   synchronous clear of all counters
//   <CMD>_LOW/HIGH_ADDR       inclusive match window per command (24 bit)
//   PRGEXCT..WRSTAT           per-command hit counters (32 bit)
//   TRG_PLS                   one-cycle pulse on any hit
//   TRG_SEL                   index of the last hit source (held)
module ptmch_spi_cmd_match #(
  parameter logic [7:0] OP_PRGEXCT = 8'h10,
  parameter logic [7:0] OP_RDSTAT  = 8'h0F,
  parameter logic [7:0] OP_BLKERS  = 8'hD8,
  parameter logic [7:0] OP_PDREAD  = 8'h13,
  parameter logic [7:0] OP_WRSTAT  = 8'h1F
) (
  input  logic        CLK100M,
  input  logic        RESET_N,
  input  logic        SPI_CS_N,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        CNT_CLR,
  input  logic [23:0] PRGEXCT_LOW_ADDR,
  input  logic [23:0] RDSTAT_LOW_ADDR,
  input  logic [23:0] BLKERS_LOW_ADDR,
  input  logic [23:0] PDREAD_LOW_ADDR,
  input  logic [23:0] WRSTAT_LOW_ADDR,
  input  logic [23:0] PRGEXCT_HIGH_ADDR,
  input  logic [23:0] RDSTAT_HIGH_ADDR,
  input  logic [23:0] BLKERS_HIGH_ADDR,
  input  logic [23:0] PDREAD_HIGH_ADDR,
  input  logic [23:0] WRSTAT_HIGH_ADDR,
  output logic [31:0] PRGEXCT,
  output logic [31:0] RDSTAT,
  output logic [31:0] BLKERS,
  output logic [31:0] PDREAD,
  output logic [31:0] WRSTAT,
  output logic        TRG_PLS,
  output logic [2:0]  TRG_SEL
);

  typedef enum logic [2:0] {S_IDLE, S_OPC, S_FLD, S_CMP, S_SKIP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  sck_sync_q, sck_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        sck_prev_q, sck_prev_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  need_q, need_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  sh_q, sh_d;
  logic [23:0] field_q, field_d;
  logic [31:0] cnt_q [5];
  logic [31:0] cnt_d [5];
  logic        trg_pls_q, trg_pls_d;
  logic [2:0]  trg_sel_q, trg_sel_d;

  logic        cs_n_s, mosi_s, sck_rise, hit;
  logic [7:0]  byte_w;
  logic [23:0] win_lo, win_hi;

  always_comb begin
    // Synchronizers; the edge detector compares against one more stage.
    cs_sync_d   = {cs_sync_q[0], SPI_CS_N};
    sck_sync_d  = {sck_sync_q[0], SPI_SCK};
    mosi_sync_d = {mosi_sync_q[0], SPI_MOSI};
    sck_prev_d  = sck_sync_q[1];
    cs_n_s      = cs_sync_q[1];
    mosi_s      = mosi_sync_q[1];
    sck_rise    = sck_sync_q[1] & ~sck_prev_q;
    byte_w      = {sh_q[6:0], mosi_s};

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    need_d     = need_q;
    sel_d      = sel_q;
    sh_d       = sh_q;
    field_d    = field_q;
    hit        = 1'b0;

    case (sel_q)
      3'd0:    begin win_lo = PRGEXCT_LOW_ADDR; win_hi = PRGEXCT_HIGH_ADDR; end
      3'd1:    begin win_lo = RDSTAT_LOW_ADDR;  win_hi = RDSTAT_HIGH_ADDR;  end
      3'd2:    begin win_lo = BLKERS_LOW_ADDR;  win_hi = BLKERS_HIGH_ADDR;  end
      3'd3:    begin win_lo = PDREAD_LOW_ADDR;  win_hi = PDREAD_HIGH_ADDR;  end
      default: begin win_lo = WRSTAT_LOW_ADDR;  win_hi = WRSTAT_HIGH_ADDR;  end
    endcase

    case (state_q)
      S_IDLE: begin
        if (!cs_n_s) begin
          state_d   = S_OPC;
          bit_cnt_d = 3'd0;
          sh_d      = 8'h00;
        end
      end
      S_OPC: begin
        if (cs_n_s) begin
          state_d = S_IDLE;
        end else if (sck_rise) begin
          sh_d      = byte_w;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Field is cleared here so short fields come out zero-extended.
            state_d    = S_FLD;
            byte_cnt_d = 2'd0;
            field_d    = 24'h0;
            if (byte_w == OP_PRGEXCT) begin
              sel_d = 3'd0; need_d = 2'd3;
            end else if (byte_w == OP_RDSTAT) begin
              sel_d = 3'd1; need_d = 2'd1;
            end else if (byte_w == OP_BLKERS) begin
              sel_d = 3'd2; need_d = 2'd3;
            end else if (byte_w == OP_PDREAD) begin
              sel_d = 3'd3; need_d = 2'd3;
            end else if (byte_w == OP_WRSTAT) begin
              sel_d = 3'd4; need_d = 2'd2;
            end else begin
              state_d = S_SKIP;
            end
          end
        end
      end
      S_FLD: begin
        if (cs_n_s) begin
          state_d = S_IDLE;
        end else if (sck_rise) begin
          sh_d      = byte_w;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            field_d    = {field_q[15:0], byte_w};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q + 2'd1 == need_q) state_d = S_CMP;
          end
        end
      end
      S_CMP: begin
        // CS_N is deliberately not checked here: a complete field always compares.
        hit     = (field_q >= win_lo) && (field_q <= win_hi);
        state_d = S_SKIP;
      end
      S_SKIP: begin
        if (cs_n_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over a same-cycle increment.
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hit && (sel_q == 3'(i))) cnt_d[i] = cnt_q[i] + 32'd1;
      if (CNT_CLR) cnt_d[i] = 32'd0;
    end

    trg_pls_d = hit;
    trg_sel_d = hit ? sel_q : trg_sel_q;
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      cs_sync_q   <= 2'b11;
      sck_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      need_q      <= 2'd0;
      sel_q       <= 3'd0;
      sh_q        <= 8'h00;
      field_q     <= 24'h0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= 32'd0;
      trg_pls_q   <= 1'b0;
      trg_sel_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      need_q      <= need_d;
      sel_q       <= sel_d;
      sh_q        <= sh_d;
      field_q     <= field_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      trg_pls_q   <= trg_pls_d;
      trg_sel_q   <= trg_sel_d;
    end
  end

  assign PRGEXCT = cnt_q[0];
  assign RDSTAT  = cnt_q[1];
  assign BLKERS  = cnt_q[2];
  assign PDREAD  = cnt_q[3];
  assign WRSTAT  = cnt_q[4];
  assign TRG_PLS = trg_pls_q;
  assign TRG_SEL = trg_sel_q;

endmodule

// File: tb/tb_ptmch_spi_cmd_match.sv
// Testbench for ptmch_spi_cmd_match: directed vector table, hand-written
// corner sequences (wrap, clear priority, mid-frame reset) and randomized
// frames checked against a frame-level reference model.
module tb_ptmch_spi_cmd_match;

  logic        CLK100M = 1'b0;
  logic        RESET_N, SPI_CS_N, SPI_SCK, SPI_MOSI, CNT_CLR;
  logic [23:0] lo [5];
  logic [23:0] hi [5];
  logic [31:0] o_prg, o_rd, o_blk, o_pd, o_wr;
  logic        TRG_PLS;
  logic [2:0]  TRG_SEL;

  ptmch_spi_cmd_match dut (
    .CLK100M(CLK100M), .RESET_N(RESET_N),
    .SPI_CS_N(SPI_CS_N), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .CNT_CLR(CNT_CLR),
    .PRGEXCT_LOW_ADDR(lo[0]), .RDSTAT_LOW_ADDR(lo[1]), .BLKERS_LOW_ADDR(lo[2]),
    .PDREAD_LOW_ADDR(lo[3]), .WRSTAT_LOW_ADDR(lo[4]),
    .PRGEXCT_HIGH_ADDR(hi[0]), .RDSTAT_HIGH_ADDR(hi[1]), .BLKERS_HIGH_ADDR(hi[2]),
    .PDREAD_HIGH_ADDR(hi[3]), .WRSTAT_HIGH_ADDR(hi[4]),
    .PRGEXCT(o_prg), .RDSTAT(o_rd), .BLKERS(o_blk), .PDREAD(o_pd), .WRSTAT(o_wr),
    .TRG_PLS(TRG_PLS), .TRG_SEL(TRG_SEL)
  );

  always #5 CLK100M = ~CLK100M;

  int n_chk  = 0;
  int n_pass = 0;

  // Pulse monitor: total high cycles and number of distinct pulses.
  int   pls_cycles = 0;
  int   pls_edges  = 0;
  logic pls_prev   = 1'b0;
  always @(negedge CLK100M) begin
    if (TRG_PLS) begin
      pls_cycles <= pls_cycles + 1;
      if (!pls_prev) pls_edges <= pls_edges + 1;
    end
    pls_prev <= TRG_PLS;
  end

  // Reference state
  logic [31:0] mcnt [5];
  logic [2:0]  msel;

  typedef struct {
    logic [0:7][7:0] b;
    int              len;
    int              idx;   // window under test, -1 none
    logic [23:0]     wlo;
    logic [23:0]     whi;
    bit              open;  // all other windows 0..FFFFFF
    int              hit;
    string           nm;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] dut_cnt(int i);
    case (i)
      0: return o_prg;
      1: return o_rd;
      2: return o_blk;
      3: return o_pd;
      default: return o_wr;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic spi_bit(logic v);
    SPI_MOSI = v;
    #40 SPI_SCK = 1'b1;
    #40 SPI_SCK = 1'b0;
  endtask

  task automatic send_frame(logic [0:7][7:0] b, int len);
    SPI_CS_N = 1'b0;
    #60;
    for (int i = 0; i < len; i++)
      for (int k = 7; k >= 0; k--) spi_bit(b[i][k]);
    #40 SPI_CS_N = 1'b1;
    #100;
  endtask

  // Frame-level model: decides from the opcode, the number of bytes that
  // actually arrived and the window whether this frame counts.
  function automatic int model_frame(logic [0:7][7:0] b, int len);
    int idx, need;
    logic [23:0] field;
    case (b[0])
      8'h10: begin idx = 0; need = 3; end
      8'h0F: begin idx = 1; need = 1; end
      8'hD8: begin idx = 2; need = 3; end
      8'h13: begin idx = 3; need = 3; end
      8'h1F: begin idx = 4; need = 2; end
      default: return 0;
    endcase
    if (len < 1 + need) return 0;
    field = 24'h0;
    for (int j = 1; j <= need; j++) field = (field << 8) | 24'(b[j]);
    if (field < lo[idx] || field > hi[idx]) return 0;
    mcnt[idx] = mcnt[idx] + 32'd1;
    msel      = 3'(idx);
    return 1;
  endfunction

  task automatic check_state(string nm, int exp_p, int p0, int e0);
    for (int i = 0; i < 5; i++) chk($sformatf("%s cnt%0d", nm, i), dut_cnt(i), mcnt[i]);
    chk($sformatf("%s pulse_cycles", nm), 32'(pls_cycles - p0), 32'(exp_p));
    chk($sformatf("%s pulse_count", nm), 32'(pls_edges - e0), 32'(exp_p));
    chk($sformatf("%s trg_sel", nm), 32'(TRG_SEL), 32'(msel));
  endtask

  task automatic run_frame(string nm, logic [0:7][7:0] b, int len, output int got_p);
    int p0, e0, ep;
    p0 = pls_cycles;
    e0 = pls_edges;
    send_frame(b, len);
    ep = model_frame(b, len);
    check_state(nm, ep, p0, e0);
    got_p = pls_edges - e0;
  endtask

  task automatic set_windows(bit open);
    @(negedge CLK100M);
    for (int i = 0; i < 5; i++) begin
      lo[i] = open ? 24'h000000 : 24'hFFFFFF;
      hi[i] = open ? 24'hFFFFFF : 24'h000000;
    end
  endtask

  initial begin
    int got, p0, e0, need, op_i, len;
    bit seen;
    logic [0:7][7:0] fb;
    logic [7:0] ops [6];

    RESET_N  = 1'b0;
    SPI_CS_N = 1'b1;
    SPI_SCK  = 1'b0;
    SPI_MOSI = 1'b0;
    CNT_CLR  = 1'b0;
    for (int i = 0; i < 5; i++) begin lo[i] = 24'h0; hi[i] = 24'h0; mcnt[i] = 32'd0; end
    lo[0] = 24'hFFFFFF; hi[0] = 24'hFFFFFF;
    msel = 3'd0;

    // Reset state
    repeat (3) @(negedge CLK100M);
    for (int i = 0; i < 5; i++) chk($sformatf("reset cnt%0d", i), dut_cnt(i), 32'd0);
    chk("reset trg_pls", 32'(TRG_PLS), 32'd0);
    chk("reset trg_sel", 32'(TRG_SEL), 32'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK100M);

    // Directed vector table
    tbl.push_back('{64'h13000120_00000000, 4, 3, 24'h000100, 24'h0001FF, 0, 1, "pdread_hit"});
    tbl.push_back('{64'h13000200_00000000, 4, 3, 24'h000100, 24'h0001FF, 0, 0, "pdread_miss"});
    tbl.push_back('{64'hD8000040_00000000, 4, 2, 24'h000040, 24'h000040, 0, 1, "blkers_eq"});
    tbl.push_back('{64'hD800003F_00000000, 4, 2, 24'h000040, 24'h000040, 0, 0, "blkers_below"});
    tbl.push_back('{64'hD8000041_00000000, 4, 2, 24'h000040, 24'h000040, 0, 0, "blkers_above"});
    tbl.push_back('{64'h13000100_00000000, 3, 3, 24'h000100, 24'h0001FF, 0, 0, "pdread_abort"});
    tbl.push_back('{64'h13000120_00000000, 4, 3, 24'h000100, 24'h0001FF, 0, 1, "pdread_after_abort"});
    tbl.push_back('{64'h0FC01122_33440000, 6, 1, 24'h0000C0, 24'h0000C0, 0, 1, "rdstat_status"});
    tbl.push_back('{64'h1FA07C00_00000000, 3, 4, 24'h00A000, 24'h00A0FF, 0, 1, "wrstat_hit"});
    tbl.push_back('{64'h9F000120_00000000, 4, -1, 24'h0, 24'h0, 1, 0, "unknown_op"});
    tbl.push_back('{64'h10FFFFFF_00000000, 4, 0, 24'hFFFFFF, 24'hFFFFFF, 0, 1, "prgexct_rst_win"});
    tbl.push_back('{64'h10FFFFFE_00000000, 4, 0, 24'hFFFFFF, 24'hFFFFFF, 0, 0, "prgexct_rst_miss"});
    tbl.push_back('{64'h13000150_00000000, 4, 3, 24'h000200, 24'h000100, 0, 0, "inverted_win"});
    tbl.push_back('{64'h0F0A0000_00000000, 1, 1, 24'h000000, 24'hFFFFFF, 0, 0, "opcode_only"});

    foreach (tbl[t]) begin
      set_windows(tbl[t].open);
      if (tbl[t].idx >= 0) begin
        lo[tbl[t].idx] = tbl[t].wlo;
        hi[tbl[t].idx] = tbl[t].whi;
      end
      run_frame(tbl[t].nm, tbl[t].b, tbl[t].len, got);
      chk({tbl[t].nm, " table_hit"}, 32'(got), 32'(tbl[t].hit));
    end

    // Wrap: preload PDREAD with all-ones, then hit
    set_windows(0);
    lo[3] = 24'h000100; hi[3] = 24'h0001FF;
    dut.cnt_q[3] = 32'hFFFFFFFF;
    mcnt[3] = 32'hFFFFFFFF;
    run_frame("wrap", 64'h13000120_00000000, 4, got);

    // Give PDREAD a nonzero value, then clear it in the hit cycle
    run_frame("pre_clr", 64'h13000120_00000000, 4, got);
    @(negedge CLK100M);
    CNT_CLR = 1'b1;
    p0 = pls_cycles;
    e0 = pls_edges;
    seen = 0;
    fork
      send_frame(64'h13000120_00000000, 4);
      begin
        for (int c = 0; c < 2000 && !seen; c++) begin
          @(negedge CLK100M);
          if (TRG_PLS) begin
            CNT_CLR = 1'b0;
            seen = 1;
          end
        end
      end
    join
    CNT_CLR = 1'b0;
    chk("clr_hit pulse_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) mcnt[i] = 32'd0;
    msel = 3'd3;
    check_state("clr_hit", 1, p0, e0);

    // Reset mid-field after a counted hit
    run_frame("pre_reset", 64'h13000120_00000000, 4, got);
    p0 = pls_cycles;
    e0 = pls_edges;
    fb = 64'h13000100_00000000;
    SPI_CS_N = 1'b0;
    #60;
    for (int i = 0; i < 2; i++)
      for (int k = 7; k >= 0; k--) spi_bit(fb[i][k]);
    for (int k = 7; k >= 4; k--) spi_bit(fb[2][k]);
    @(negedge CLK100M);
    RESET_N = 1'b0;
    @(negedge CLK100M);
    for (int i = 0; i < 5; i++) chk($sformatf("midreset cnt%0d", i), dut_cnt(i), 32'd0);
    chk("midreset trg_pls", 32'(TRG_PLS), 32'd0);
    chk("midreset trg_sel", 32'(TRG_SEL), 32'd0);
    @(negedge CLK100M);
    RESET_N = 1'b1;
    for (int k = 3; k >= 0; k--) spi_bit(fb[2][k]);
    #40 SPI_CS_N = 1'b1;
    #100;
    for (int i = 0; i < 5; i++) mcnt[i] = 32'd0;
    msel = 3'd0;
    check_state("post_reset", 0, p0, e0);
    run_frame("after_reset", 64'h13000120_00000000, 4, got);

    // Randomized frames against the model
    ops[0] = 8'h10; ops[1] = 8'h0F; ops[2] = 8'hD8;
    ops[3] = 8'h13; ops[4] = 8'h1F; ops[5] = 8'h9F;
    for (int it = 0; it < 40; it++) begin
      @(negedge CLK100M);
      for (int i = 0; i < 5; i++) begin
        lo[i] = 24'($urandom_range(0, 255));
        hi[i] = 24'($urandom_range(0, 255));
      end
      op_i = $urandom_range(0, 5);
      case (op_i)
        1: need = 1;
        4: need = 2;
        default: need = 3;
      endcase
      fb = '0;
      fb[0] = ops[op_i];
      for (int j = 1; j < 8; j++) fb[j] = 8'($urandom_range(0, 255));
      for (int j = 1; j < need; j++)
        if ($urandom_range(0, 7) != 0) fb[j] = 8'h00;
      if ($urandom_range(0, 4) == 0) len = $urandom_range(1, need);
      else len = 1 + need + $urandom_range(0, 2);
      run_frame($sformatf("rand%0d", it), fb, len, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
